// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared types and constants for the sequential ALU.
//               Contents: the opcode enum, the control FSM state enum, the
//               flag bit positions, and a helper that identifies the opcodes
//               handled by the iterative unit.
//               Optional macro SEQ_ALU_DIV_EN makes opcode 1111 an iterative
//               divide instead of PASS B.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_NOT  = 4'b0101,
      OP_SHL  = 4'b0110,
      OP_SHR  = 4'b0111,
      OP_ASR  = 4'b1000,
      OP_ROL  = 4'b1001,
      OP_ROR  = 4'b1010,
      OP_INC  = 4'b1011,
      OP_DEC  = 4'b1100,
      OP_CMP  = 4'b1101,
      OP_MUL  = 4'b1110,
      OP_PDIV = 4'b1111   // PASS B, or DIV when the divider is built
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit positions inside flags = {carry, zero, neg, ovf}
   localparam int FLG_C = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_N = 1;
   localparam int FLG_V = 0;

   // True for opcodes that run through the multi-cycle iterative unit
   function automatic logic is_iter_op(input logic [3:0] opc);
`ifdef SEQ_ALU_DIV_EN
      return (opc == OP_MUL) || (opc == OP_PDIV);
`else
      return (opc == OP_MUL);
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_iter
// Description : Iterative arithmetic unit. It contains a WIDTH-step
//               shift-add multiplier. When SEQ_ALU_DIV_EN is defined, it also
//               contains a WIDTH-step restoring divider that shares the
//               same 2*WIDTH working register.
// Ports       : clk, rst_n       - clock, async active-low reset
//               start            - load operands (one-cycle pulse)
//               div              - (SEQ_ALU_DIV_EN) select divide on start
//               a, b             - operands sampled on start
//               done             - final step is being taken this cycle
//               res_lo, res_hi   - value of the working register after the
//                                  current step (valid when done=1)
//               div_mode,div_zero- (SEQ_ALU_DIV_EN) op kind / divisor == 0
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_iter
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SEQ_ALU_DIV_EN
   input  logic             div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
`ifdef SEQ_ALU_DIV_EN
   ,
   output logic             div_mode,
   output logic             div_zero
`endif
);

   localparam int             SHW  = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   logic               busy_q, busy_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi: partial product / remainder, lo: multiplier / quotient}
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_step;
`ifdef SEQ_ALU_DIV_EN
   logic               div_q, div_d;
   logic [WIDTH:0]     w_rsh;
   logic [WIDTH-1:0]   w_diff;
`endif

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opnd_d = opnd_q;
`ifdef SEQ_ALU_DIV_EN
      div_d  = div_q;
`endif

      // Multiply step: conditionally add the multiplicand into the high half,
      // then shift the whole register right by one. The carry drops into the MSB.
      w_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      w_step = {w_sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
      // Divide step: shift the next dividend bit into the remainder and
      // subtract the divisor if it fits. The remainder is always below the
      // divisor, so the difference fits in WIDTH bits. For a zero divisor,
      // this yields an all-ones quotient and remainder = A.
      w_rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      w_diff = w_rsh[WIDTH-1:0] - opnd_q;
      if (div_q) begin
         if (w_rsh >= {1'b0, opnd_q})
            w_step = {w_diff, acc_q[WIDTH-2:0], 1'b1};
         else
            w_step = {w_rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
`endif

      done = busy_q && (cnt_q == LAST);

      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         opnd_d = a;
         acc_d  = {{WIDTH{1'b0}}, b};
`ifdef SEQ_ALU_DIV_EN
         div_d  = div;
         if (div) begin
            opnd_d = b;
            acc_d  = {{WIDTH{1'b0}}, a};
         end
`endif
      end else if (busy_q) begin
         acc_d = w_step;
         cnt_d = cnt_q + SHW'(1);
         if (done)
            busy_d = 1'b0;
      end
   end

   // The final result is taken from the step value, so the top module can
   // register it on the same edge that completes the last iteration.
   assign res_lo = w_step[WIDTH-1:0];
   assign res_hi = w_step[2*WIDTH-1:WIDTH];

`ifdef SEQ_ALU_DIV_EN
   assign div_mode = div_q;
   assign div_zero = div_q && (opnd_q == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
`ifdef SEQ_ALU_DIV_EN
         div_q  <= 1'b0;
`endif
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
`ifdef SEQ_ALU_DIV_EN
         div_q  <= div_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Registered 16-operation ALU with valid/ready handshakes on
//               input and output. It provides {carry, zero, neg, ovf} flags.
//               MUL is multi-cycle (WIDTH+1 cycles) through seq_alu_iter.
//               Optional macro SEQ_ALU_DIV_EN: op 1111 becomes an unsigned
//               restoring divide (quotient -> result, remainder ->
//               result_hi). Otherwise op 1111 is PASS B.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid/in_ready     - operand handshake
//               a, b [WIDTH], op [4]  - operands and opcode
//               out_valid/out_ready   - result handshake
//               result [WIDTH]        - result (low half for MUL)
//               result_hi [WIDTH]     - MUL high half / remainder, else 0
//               flags [4]             - {carry, zero, neg, ovf}
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic [3:0]       flags_q, flags_d;

   logic             w_accept;
   logic             iter_start;
   logic             iter_done;
   logic [WIDTH-1:0] iter_lo, iter_hi;
   logic [3:0]       w_iter_flags;
`ifdef SEQ_ALU_DIV_EN
   logic             iter_div_mode;
   logic             iter_div_zero;
`endif

   logic [SHW-1:0]   w_amt;
   logic [SHW:0]     w_inv;
   logic [WIDTH:0]   w_add, w_sub;
   logic [WIDTH-1:0] w_res;
   logic             w_c, w_v;
   logic [3:0]       w_flags;

   // ------------------------------------------------------------------
   // Shift amount. If WIDTH is not a power of two, the SHW-bit amount
   // can reach WIDTH or beyond. In that case, fold it back once so that
   // rotates stay modular.
   // ------------------------------------------------------------------
   generate
      if (WIDTH == (1 << SHW)) begin : g_amt_pow2
         assign w_amt = b[SHW-1:0];
      end else begin : g_amt_fold
         assign w_amt = (b[SHW-1:0] >= SHW'(WIDTH)) ? (b[SHW-1:0] - SHW'(WIDTH)) : b[SHW-1:0];
      end
   endgenerate

   // Complementary amount for rotates. An amount of 0 gives WIDTH, and the
   // shift by WIDTH contributes 0.
   assign w_inv = (SHW+1)'(WIDTH) - {1'b0, w_amt};

   // ------------------------------------------------------------------
   // Single-cycle operation decode
   // ------------------------------------------------------------------
   always_comb begin
      w_add = {1'b0, a} + {1'b0, b};
      w_sub = {1'b0, a} - {1'b0, b};
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
         end
         OP_SUB: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];                // borrow
            w_v   = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
         end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_NOT: w_res = ~a;
         OP_SHL: w_res = a << w_amt;
         OP_SHR: w_res = a >> w_amt;
         OP_ASR: w_res = $signed(a) >>> w_amt;
         OP_ROL: w_res = (a << w_amt) | (a >> w_inv);
         OP_ROR: w_res = (a >> w_amt) | (a << w_inv);
         OP_INC: begin
            w_res = a + {{(WIDTH-1){1'b0}}, 1'b1};
            w_v   = (a == {1'b0, {(WIDTH-1){1'b1}}});
         end
         OP_DEC: begin
            w_res = a - {{(WIDTH-1){1'b0}}, 1'b1};
            w_v   = (a == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_CMP: begin
            w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
            w_c   = w_sub[WIDTH];
            w_v   = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
         end
`ifndef SEQ_ALU_DIV_EN
         OP_PDIV: w_res = b;
`endif
         default: w_res = '0;                     // iterative ops
      endcase

      w_flags        = '0;
      w_flags[FLG_C] = w_c;
      w_flags[FLG_Z] = (w_res == '0);
      w_flags[FLG_N] = w_res[MSB];
      w_flags[FLG_V] = w_v;
   end

   // ------------------------------------------------------------------
   // Iterative unit and its flags
   // ------------------------------------------------------------------
   seq_alu_iter #(
      .WIDTH    (WIDTH)
   ) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (iter_start),
`ifdef SEQ_ALU_DIV_EN
      .div      (op == OP_PDIV),
`endif
      .a        (a),
      .b        (b),
      .done     (iter_done),
      .res_lo   (iter_lo),
      .res_hi   (iter_hi)
`ifdef SEQ_ALU_DIV_EN
      ,
      .div_mode (iter_div_mode),
      .div_zero (iter_div_zero)
`endif
   );

   always_comb begin
      w_iter_flags        = '0;
      w_iter_flags[FLG_Z] = ({iter_hi, iter_lo} == '0);   // MUL: both halves
      w_iter_flags[FLG_N] = iter_lo[MSB];
`ifdef SEQ_ALU_DIV_EN
      if (iter_div_mode) begin
         w_iter_flags[FLG_Z] = (iter_lo == '0);
         w_iter_flags[FLG_V] = iter_div_zero;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Control FSM: next state, handshakes and result capture
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flags_d     = flags_q;
      iter_start  = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            w_accept = in_valid;
         end
         BUSY: begin
            if (iter_done) begin
               result_d    = iter_lo;
               result_hi_d = iter_hi;
               flags_d     = w_iter_flags;
               state_d     = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // If the consumer drains the result, a new operand can be taken
            // in the same cycle, so back-to-back ops need no idle cycle.
            if (out_ready) begin
               in_ready = 1'b1;
               w_accept = in_valid;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (w_accept) begin
         if (is_iter_op(op)) begin
            iter_start = 1'b1;
            state_d    = BUSY;
         end else begin
            result_d    = w_res;
            result_hi_d = '0;
            flags_d     = w_flags;
            state_d     = DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flags_q     <= flags_d;
      end
   end

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu with WIDTH=8. It runs a
//               table of single-cycle vectors and hand-written sequences for
//               MUL latency, backpressure, and reset during BUSY. It runs
//               divider cases when SEQ_ALU_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic [3:0]   flags;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [3:0]   fl;     // {C,Z,N,V}
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [3:0]   fl;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard: each output transfer is compared against the oldest expectation
   exp_t mon_e;
   int   mon_idx = 0;
   always @(negedge clk) begin
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out%0d.unexpected: got an output transfer, expected none", mon_idx);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("out%0d.result", mon_idx), 32'(result), 32'(mon_e.res));
            check($sformatf("out%0d.result_hi", mon_idx), 32'(result_hi), 32'(mon_e.hi));
            check($sformatf("out%0d.flags", mon_idx), 32'(flags), 32'(mon_e.fl));
         end
         mon_idx++;
      end
   end

   // Called just after a negedge. Returns the cycle index of the transfer
   // cycle, and returns just after the accepting posedge.
   task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e, output int acc, output bit ok);
      int n;
      op = o; a = x; b = y; in_valid = 1'b1;
      ok = 1'b0; acc = -1; n = 0;
      while (!ok && n < 40) begin
         #1;
         if (in_ready) ok = 1'b1;
         else begin
            n++;
            @(negedge clk);
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept: in_ready got 0 for %0d cycles, expected 1", n);
         in_valid = 1'b0;
      end else begin
         acc = cyc;
         sb.push_back(e);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_out(input string nm, input int acc, input int lat, input bit busy_chk);
      bit seen;
      int n;
      seen = 1'b0; n = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         #2;
         n++;
         if (out_valid) seen = 1'b1;
         else if (busy_chk) check({nm, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      end
      check({nm, ".latency"}, seen ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'(lat));
   endtask

   initial begin
      int acc;
      bit ok;

      // op, a, b, result, flags{C,Z,N,V}
      vecs.push_back('{4'b0000, 8'hF0, 8'h20, 8'h10, 4'b1000}); // ADD carry
      vecs.push_back('{4'b0000, 8'h7F, 8'h01, 8'h80, 4'b0011}); // ADD ovf
      vecs.push_back('{4'b0001, 8'h7F, 8'hFF, 8'h80, 4'b1011}); // SUB borrow+ovf
      vecs.push_back('{4'b1101, 8'h03, 8'h05, 8'h01, 4'b1000}); // CMP lt
      vecs.push_back('{4'b1101, 8'h05, 8'h03, 8'h00, 4'b0100}); // CMP ge
      vecs.push_back('{4'b0010, 8'hCC, 8'hAA, 8'h88, 4'b0010}); // AND
      vecs.push_back('{4'b0011, 8'h0F, 8'hF0, 8'hFF, 4'b0010}); // OR
      vecs.push_back('{4'b0100, 8'h5A, 8'h5A, 8'h00, 4'b0100}); // XOR zero
      vecs.push_back('{4'b0101, 8'h0F, 8'h00, 8'hF0, 4'b0010}); // NOT
      vecs.push_back('{4'b0110, 8'h81, 8'h03, 8'h08, 4'b0000}); // SHL
      vecs.push_back('{4'b0111, 8'h81, 8'h0F, 8'h01, 4'b0000}); // SHR, amount masked to 7
      vecs.push_back('{4'b1000, 8'h80, 8'h02, 8'hE0, 4'b0010}); // ASR
      vecs.push_back('{4'b1001, 8'h81, 8'h01, 8'h03, 4'b0000}); // ROL
      vecs.push_back('{4'b1010, 8'h81, 8'h01, 8'hC0, 4'b0010}); // ROR
      vecs.push_back('{4'b0110, 8'h96, 8'h08, 8'h96, 4'b0010}); // SHL by 0
      vecs.push_back('{4'b1001, 8'h96, 8'h00, 8'h96, 4'b0010}); // ROL by 0
      vecs.push_back('{4'b1011, 8'h7F, 8'h00, 8'h80, 4'b0011}); // INC ovf
      vecs.push_back('{4'b1100, 8'h80, 8'h00, 8'h7F, 4'b0001}); // DEC ovf
`ifndef SEQ_ALU_DIV_EN
      vecs.push_back('{4'b1111, 8'h11, 8'h3C, 8'h3C, 4'b0000}); // PASS B
`endif

      // Reset state
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.result", 32'(result), 32'd0);
      check("reset.result_hi", 32'(result_hi), 32'd0);
      check("reset.flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle table
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         send(vecs[i].op, vecs[i].a, vecs[i].b, '{vecs[i].res, 8'h00, vecs[i].fl}, acc, ok);
         if (ok) wait_out($sformatf("vec%0d", i), acc, 1, 1'b0);
      end

      // MUL with full-scale operands: 9-cycle latency, not ready while busy
      @(negedge clk);
      send(4'b1110, 8'hFF, 8'hFF, '{8'h01, 8'hFE, 4'b0000}, acc, ok);
      if (ok) wait_out("mul_ff", acc, 9, 1'b1);
      @(negedge clk);
      send(4'b1110, 8'h00, 8'h5A, '{8'h00, 8'h00, 4'b0100}, acc, ok);
      if (ok) wait_out("mul_zero", acc, 9, 1'b1);

      // Backpressure: ADD result held for 5 cycles with out_ready low
      @(negedge clk);
      out_ready = 1'b0;
      send(4'b0000, 8'h12, 8'h34, '{8'h46, 8'h00, 4'b0000}, acc, ok);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d.result", k), 32'(result), 32'h46);
         check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
      end
      // Release with a queued XOR: both transfers share one edge
      @(negedge clk);
      out_ready = 1'b1;
      send(4'b0100, 8'hF0, 8'h3C, '{8'hCC, 8'h00, 4'b0010}, acc, ok);
      check("bp.add_drained", 32'(sb.size()), 32'd1);
      if (ok) wait_out("bp_xor", acc, 1, 1'b0);

      // Reset three cycles into a MUL
      @(negedge clk);
      send(4'b0000, 8'h21, 8'h11, '{8'h32, 8'h00, 4'b0000}, acc, ok);
      if (ok) wait_out("pre_rst_add", acc, 1, 1'b0);
      @(negedge clk);
      send(4'b1110, 8'h12, 8'h34, '{8'hA8, 8'h03, 4'b0010}, acc, ok);
      repeat (3) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid.out_valid", 32'(out_valid), 32'd0);
      check("rst_mid.result", 32'(result), 32'd0);
      check("rst_mid.result_hi", 32'(result_hi), 32'd0);
      check("rst_mid.flags", 32'(flags), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rel.in_ready", 32'(in_ready), 32'd1);
      repeat (12) @(negedge clk);
      #1;
      check("rst_rel.out_valid", 32'(out_valid), 32'd0);

      // Recovery after reset
      @(negedge clk);
      send(4'b1110, 8'h10, 8'h10, '{8'h00, 8'h01, 4'b0000}, acc, ok);
      if (ok) wait_out("mul_after_rst", acc, 9, 1'b1);

`ifdef SEQ_ALU_DIV_EN
      @(negedge clk);
      send(4'b1111, 8'd100, 8'd7, '{8'd14, 8'd2, 4'b0000}, acc, ok);
      if (ok) wait_out("div_100_7", acc, 9, 1'b1);
      @(negedge clk);
      send(4'b1111, 8'h55, 8'h00, '{8'hFF, 8'h55, 4'b0011}, acc, ok);
      if (ok) wait_out("div_zero", acc, 9, 1'b1);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time got %0t, expected finish before 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Performs 16 operations on WIDTH-bit operands.
- Uses valid/ready handshakes on both input and output, produces status flags, and runs a multi-cycle shift-add multiplier.
- Sits between the operand register file and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand and result width; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount bits taken from B; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand and op presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation select
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result; low half for MUL
- result_hi  out  WIDTH  MUL high half; 0 for all other ops
- flags  out  4  {carry, zero, neg, ovf}

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; result, result_hi, flags=0. Any operation in flight is discarded.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: multi-cycle op in progress; in_ready=0.
  - DONE: out_valid=1; outputs held stable until out_ready=1.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Single-cycle ops: transfer in cycle N -> out_valid and result registered at edge N+1 (state DONE).
- MUL (op 1110): IDLE -> BUSY.
  - WIDTH iterations of shift-add; DONE is entered WIDTH+1 cycles after acceptance.
  - a and b are latched at acceptance, so later input changes are ignored.
- DONE with out_ready=1:
  - in_ready=1 in the same cycle, so back-to-back ops are accepted with no bubble.
  - New input present -> DONE again for single-cycle ops, BUSY for MUL.
  - No new input -> IDLE.
- DONE with out_ready=0: hold state and outputs; in_ready=0.
- Op map (all results WIDTH bits, wrap modulo 2^WIDTH):
  - 0000 ADD: carry = carry-out.
  - 0001 SUB: A-B; carry = borrow.
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A.
  - 0110 SHL, 0111 SHR (logical), 1000 ASR, 1001 ROL, 1010 ROR: amount = b[SHW-1:0].
  - 1011 INC A, 1100 DEC A.
  - 1101 CMP: result = 1 if A<B unsigned, else 0; carry/ovf taken from A-B.
  - 1110 MUL: unsigned; {result_hi, result} = A*B.
  - 1111: PASS B, unless the optional feature below is enabled.
- Flags:
  - zero = all result bits 0; for MUL this covers both halves.
  - neg = result MSB.
  - ovf = signed overflow for ADD, SUB, INC, DEC, CMP; 0 otherwise.
  - carry = 0 for ops that do not define it.
- Shifts with amount 0 pass A through unchanged, with carry=0.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: op 1111 = unsigned restoring divide, WIDTH+1 cycles via BUSY.
  - result = quotient, result_hi = remainder.
  - Divide by zero: quotient all ones, remainder = A, ovf=1, latency unchanged.
- Undefined: op 1111 = PASS B, single cycle, and no divider logic is synthesised.

Decomposition:
- Package seq_alu_pkg holds:
  - op_e enum of the 16 opcodes.
  - state_e {IDLE, BUSY, DONE}.
  - Flag index constants FLG_C=3, FLG_Z=2, FLG_N=1, FLG_V=0.
- One sub-module, seq_alu_iter:
  - Sequential shift-add multiplier; also restoring divider when SEQ_ALU_DIV_EN is defined.
  - Interface: start/done, WIDTH-parametrised.
- The combinational op decode stays in the top module.

Test Plan (WIDTH=8):
- ADD a=8'hF0, b=8'h20, out_ready=1 -> out_valid one cycle after acceptance; result=8'h10; flags C=1, Z=0, N=0, V=0.
- SUB a=8'h7F, b=8'hFF -> result=8'h80; flags C=1 (borrow), N=1, V=1. CMP a=3, b=5 -> result=1.
- MUL a=8'hFF, b=8'hFF -> in_ready=0 during BUSY; out_valid exactly 9 cycles after acceptance; result_hi=8'hFE, result=8'h01. MUL 0*x -> Z=1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD -> result stable, in_ready=0. Raise out_ready with a queued XOR -> both transfers occur in the same cycle; XOR result appears next cycle.
- Reset mid-MUL: drop rst_n 3 cycles into BUSY -> out_valid=0 and outputs 0 immediately (asynchronously); after release, state=IDLE and in_ready=1.
- SEQ_ALU_DIV_EN defined:
  - 8'd100 / 8'd7 -> result=14, result_hi=2.
  - Divide by 0 -> result=8'hFF, result_hi=A, V=1.
  - Undefined build: op 1111 -> result=b after 1 cycle.
